ex_div_ctrl: RTL and testbench
==============================

# ex_div_ctrl

Multi-cycle divide sequencer for the execute stage, covering the RISC-V M-extension DIV, DIVU, REM and REMU operations. `execute_alu` hands the operation over with a held start request. The block runs a 32-iteration restoring division, one quotient bit per cycle. It holds the execute-stage stall request until the result is ready, then returns the result with a ready handshake.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is supported; the iteration count equals `WIDTH`.

Ports:
- Reset is asynchronous and active-low.
- `clk`  in  1  system clock; rising edge active.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  divide request from `execute_alu`; held high until `ready_o` has been seen.
- `annul_i`  in  1  flush; abandons any operation in progress.
- `signed_i`  in  1  1 = DIV/REM (two's complement); 0 = DIVU/REMU.
- `rem_sel_i`  in  1  1 = return remainder; 0 = return quotient.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `result_o`  out  32  quotient or remainder; registered.
- `ready_o`  out  1  result valid; registered.
- `stallreq_o`  out  1  stall request into the pipeline controller (`stallreq_ex` path); combinational.

## Operation
- FSM states: IDLE, ON, END.
- **IDLE**
  - Trigger: `start_i`=1 and `annul_i`=0.
  - The block latches `signed_i`, `rem_sel_i` and the operand signs.
  - It latches absolute values of the operands: `|x|` when signed, raw value when unsigned.
  - Divisor = 0: load quotient = 0xFFFFFFFF and remainder = dividend (raw, not absolute), then go to END.
  - Otherwise: clear the 6-bit iteration counter, load the 65-bit working register with {33'b0, |dividend|}, then go to ON.
- **ON**, each cycle:
  - Shift the working register left by 1.
  - Form a 33-bit trial = upper 33 bits − {1'b0, |divisor|}.
  - If the trial is non-negative: upper part = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - Increment the counter. After the 32nd iteration, go to END.
- **Sign fix** on entry to END (signed ops only):
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
  - Overflow case 0x80000000 / −1 needs no special path: it yields quotient 0x80000000 and remainder 0.
- **END**
  - `ready_o`=1 and `result_o` = the selected value.
  - Hold both until `start_i`=0, then go to IDLE, clear `ready_o` and zero `result_o`.
- **Annul:** `annul_i`=1 in ON or END forces IDLE on the next edge with `ready_o`=0. In IDLE, `annul_i` blocks the start. Annul has priority over start.
- **Input changes:** operand and control changes after the start is accepted are ignored.
- **Stall request:** `stallreq_o` = `start_i` & ~`ready_o` & ~`annul_i`.

## Timing
- **Reset:**
  - `rst`=0 immediately (asynchronously) forces IDLE, counter=0, working register=0, `result_o`=0 and `ready_o`=0.
  - This applies mid-operation too; the result is discarded.
- **Latency:** `start_i` sampled high at edge E0.
  - Nonzero divisor: ON covers edges E1..E32, so `ready_o` is high in the cycle after E32, 33 cycles after acceptance.
  - Zero divisor: `ready_o` is high in the cycle after E0, 1 cycle after acceptance.
- **Stall:** `stallreq_o` is high from the cycle `start_i` rises until the cycle `ready_o` is high; it is low in that cycle.
- **Back-to-back operations:** `start_i` must drop for at least one cycle after the END handshake. The next start is accepted from IDLE only.
- **Simultaneous events:**
  - `annul_i` and the 32nd iteration edge on the same cycle: annul wins, END is not entered.
  - `start_i` still held in END: `ready_o` stays high indefinitely, with no re-launch.

## Test plan
- **Unsigned divide and remainder:** DIVU 100/7 → `result_o`=14, `ready_o` rises 33 cycles after acceptance, `stallreq_o` high for exactly those 33 cycles. REMU 100/7 → 2.
- **Signed divide and remainder:** DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE (−2) → 0xFFFFFFFD; REM → 1.
- **Divide by zero:** DIVU 5/0 → 0xFFFFFFFF, ready 1 cycle after acceptance. REM 0xFFFFFFFB / 0 → 0xFFFFFFFB.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0. DIVU of the same operands → 0.
- **Annul mid-operation:** annul on the 10th ON cycle → `ready_o` never rises and the FSM is in IDLE next cycle. Then DIVU 6/3 → 2 after 33 cycles.
- **Reset and handshake hold:**
  - `rst` low on ON cycle 20 → `result_o`/`ready_o` are 0 immediately; after release, a fresh DIVU 9/4 → 2.
  - Holding `start_i` through END for 5 cycles → `ready_o` held for 5 cycles and no second operation starts.

Source files
------------

// File: rtl/ex_div_ctrl_if.sv
// Divide request/response bundle between execute_alu and the divider.
// Ports: start/annul/signed/rem_sel/operands in; result/ready/stallreq out.
interface ex_div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             annul_i;
   logic             signed_i;
   logic             rem_sel_i;
   logic [WIDTH-1:0] opdata1_i;
   logic [WIDTH-1:0] opdata2_i;
   logic [WIDTH-1:0] result_o;
   logic             ready_o;
   logic             stallreq_o;

   modport master (
      output start_i, annul_i, signed_i, rem_sel_i,
      output opdata1_i, opdata2_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, annul_i, signed_i, rem_sel_i,
      input  opdata1_i, opdata2_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Ports: clk, rst (async active-low), bus (ex_div_ctrl_if slave side).
module ex_div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   ex_div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_END
   } state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_t             state;
   logic [5:0]         cnt;
   logic [2*WIDTH:0]   work;
   logic [WIDTH-1:0]   dvsr;
   logic               sgn_q;
   logic               rem_q;
   logic               neg1;
   logic               neg2;
   logic [WIDTH-1:0]   result;
   logic               ready;

   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [2*WIDTH:0]   shl;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH:0]   step;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign a_abs = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ?
                  -bus.opdata1_i : bus.opdata1_i;
   assign b_abs = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ?
                  -bus.opdata2_i : bus.opdata2_i;

   // Upper WIDTH+1 bits hold the partial remainder, lower bits the quotient.
   assign shl   = work << 1;
   assign trial = shl[2*WIDTH:WIDTH] - {1'b0, dvsr};
   assign step  = trial[WIDTH] ? shl :
                  {trial, shl[WIDTH-1:1], 1'b1};

   assign quo = step[WIDTH-1:0];
   assign rem = step[2*WIDTH-1:WIDTH];

   // Quotient sign follows the operand sign mismatch, remainder the dividend.
   assign quo_fix = (sgn_q && (neg1 ^ neg2)) ? -quo : quo;
   assign rem_fix = (sgn_q && neg1) ? -rem : rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         work   <= '0;
         dvsr   <= '0;
         sgn_q  <= 1'b0;
         rem_q  <= 1'b0;
         neg1   <= 1'b0;
         neg2   <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start_i && !bus.annul_i) begin
                  sgn_q <= bus.signed_i;
                  rem_q <= bus.rem_sel_i;
                  neg1  <= bus.signed_i & bus.opdata1_i[WIDTH-1];
                  neg2  <= bus.signed_i & bus.opdata2_i[WIDTH-1];
                  dvsr  <= b_abs;
                  if (bus.opdata2_i == '0) begin
                     // Divide by zero: raw dividend as remainder, no sign fix.
                     work   <= {1'b0, bus.opdata1_i, {WIDTH{1'b1}}};
                     result <= bus.rem_sel_i ? bus.opdata1_i : '1;
                     ready  <= 1'b1;
                     state  <= S_END;
                  end else begin
                     cnt   <= '0;
                     work  <= {{(WIDTH+1){1'b0}}, a_abs};
                     state <= S_ON;
                  end
               end
            end
            S_ON: begin
               if (bus.annul_i) begin
                  state  <= S_IDLE;
                  ready  <= 1'b0;
                  result <= '0;
               end else begin
                  work <= step;
                  cnt  <= cnt + 6'd1;
                  if (cnt == LAST) begin
                     result <= rem_q ? rem_fix : quo_fix;
                     ready  <= 1'b1;
                     state  <= S_END;
                  end
               end
            end
            S_END: begin
               if (bus.annul_i || !bus.start_i) begin
                  state  <= S_IDLE;
                  ready  <= 1'b0;
                  result <= '0;
               end
            end
            default: begin
               state  <= S_IDLE;
               ready  <= 1'b0;
               result <= '0;
            end
         endcase
      end
   end

   assign bus.result_o   = result;
   assign bus.ready_o    = ready;
   assign bus.stallreq_o = bus.start_i & ~ready & ~bus.annul_i;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: vector table, random ops, corners.
// Ports: none; drives the divider through an ex_div_ctrl_if instance.
module tb_ex_div_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ex_div_ctrl_if #(.WIDTH(32)) bus ();

   ex_div_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        sgn;
      logic        rem;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   vec_t tv[$];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic sgn,
                                         input logic rem,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (!sgn) return rem ? a % b : a / b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return rem ? 32'd0 : 32'h8000_0000;
      return rem ? 32'($signed(a) % $signed(b)) :
                   32'($signed(a) / $signed(b));
   endfunction

   task automatic run_op(input logic sgn, input logic rem,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat,
                         input int hold, input string name);
      exp_t e;
      exp_t got;
      int   n;
      int   st;
      logic [31:0] held;
      e.res = res;
      e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      bus.signed_i  = sgn;
      bus.rem_sel_i = rem;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      bus.annul_i   = 1'b0;
      bus.start_i   = 1'b1;
      #1;
      st = bus.stallreq_o ? 1 : 0;
      n  = 0;
      while (n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (n == 1) begin
            // Inputs after acceptance must be ignored.
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
            bus.signed_i  = ~sgn;
            bus.rem_sel_i = ~rem;
         end
         if (bus.ready_o) break;
         if (bus.stallreq_o) st++;
      end
      got = sb.pop_front();
      chk({name, " ready"}, 32'(bus.ready_o), 32'd1);
      chk({name, " res"}, bus.result_o, got.res);
      chk({name, " lat"}, 32'(n), 32'(got.lat));
      chk({name, " stall cycles"}, 32'(st), 32'(got.lat));
      chk({name, " stall at ready"}, 32'(bus.stallreq_o), 32'd0);
      held = bus.result_o;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk({name, " hold ready"}, 32'(bus.ready_o), 32'd1);
         chk({name, " hold res"}, bus.result_o, held);
      end
      bus.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({name, " drop ready"}, 32'(bus.ready_o), 32'd0);
      chk({name, " drop res"}, bus.result_o, 32'd0);
   endtask

   task automatic quiet(input int cycles, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ready_o) seen++;
      end
      chk({name, " no ready"}, 32'(seen), 32'd0);
   endtask

   initial begin
      logic        rs;
      logic        rr;
      logic [31:0] ra;
      logic [31:0] rb;

      rst           = 1'b0;
      bus.start_i   = 1'b0;
      bus.annul_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.rem_sel_i = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;

      tv.push_back('{1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33});
      tv.push_back('{1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33});
      tv.push_back('{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
      tv.push_back('{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
      tv.push_back('{1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
      tv.push_back('{1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});
      tv.push_back('{1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
      tv.push_back('{1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1});
      tv.push_back('{1'b0, 1'b1, 32'd3, 32'd0, 32'd3, 1});
      tv.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 33});
      tv.push_back('{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});
      tv.push_back('{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});
      tv.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 33});
      tv.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33});
      tv.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 33});
      tv.push_back('{1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33});
      tv.push_back('{1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     32'hFFFF_FFFE, 33});
      tv.push_back('{1'b0, 1'b0, 32'd0, 32'd5, 32'd0, 33});

      repeat (3) @(negedge clk);
      chk("reset ready", 32'(bus.ready_o), 32'd0);
      chk("reset res", bus.result_o, 32'd0);
      chk("reset stall", 32'(bus.stallreq_o), 32'd0);
      rst = 1'b1;

      foreach (tv[i])
         run_op(tv[i].sgn, tv[i].rem, tv[i].a, tv[i].b,
                tv[i].res, tv[i].lat, 0, $sformatf("vec%0d", i));

      for (int i = 0; i < 12; i++) begin
         rs = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> (i % 24));
         run_op(rs, rr, ra, rb, model(rs, rr, ra, rb),
                (rb == 32'd0) ? 1 : 33, 0, $sformatf("rnd%0d", i));
      end

      // Annul on the 10th ON cycle.
      @(negedge clk);
      bus.signed_i  = 1'b0;
      bus.rem_sel_i = 1'b0;
      bus.opdata1_i = 32'd6;
      bus.opdata2_i = 32'd3;
      bus.start_i   = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      #1;
      chk("annul10 stall", 32'(bus.stallreq_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("annul10 ready", 32'(bus.ready_o), 32'd0);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      quiet(40, "annul10");
      run_op(1'b0, 1'b0, 32'd6, 32'd3, 32'd2, 33, 0, "after annul");

      // Annul on the same edge as the last iteration.
      @(negedge clk);
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      repeat (32) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("annul32 ready", 32'(bus.ready_o), 32'd0);
      chk("annul32 res", bus.result_o, 32'd0);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      quiet(5, "annul32");

      // Annul in IDLE blocks the start.
      @(negedge clk);
      bus.opdata2_i = 32'd0;
      bus.start_i   = 1'b1;
      bus.annul_i   = 1'b1;
      #1;
      chk("idle annul stall", 32'(bus.stallreq_o), 32'd0);
      quiet(5, "idle annul held");
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      bus.opdata2_i = 32'd7;
      quiet(40, "idle annul");

      // Reset on ON cycle 20, then reset while in END.
      @(negedge clk);
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst on ready", 32'(bus.ready_o), 32'd0);
      chk("rst on res", bus.result_o, 32'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      quiet(40, "rst on");
      @(negedge clk);
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd0;
      bus.start_i   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("pre rst end ready", 32'(bus.ready_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst end ready", 32'(bus.ready_o), 32'd0);
      chk("rst end res", bus.result_o, 32'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b0, 1'b0, 32'd9, 32'd4, 32'd2, 33, 0, "after rst");

      // Start held through END for 5 cycles in total.
      run_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33, 4, "hold");
      quiet(5, "hold after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
